// File: rtl/alu_seq_pkg.sv
// Shared decode constants, ALU codes and FSM states for alu_seq_ctrl.
package alu_seq_pkg;

    localparam logic [2:0] OpcRtype = 3'b000;
    localparam logic [2:0] OpcAddi  = 3'b001;
    localparam logic [2:0] OpcSubi  = 3'b010;

    localparam logic [3:0] FuncAdd = 4'b0000;
    localparam logic [3:0] FuncSub = 4'b0001;
    localparam logic [3:0] FuncSll = 4'b0010;
    localparam logic [3:0] FuncSlt = 4'b0011;
    localparam logic [3:0] FuncAnd = 4'b0100;
    localparam logic [3:0] FuncOr  = 4'b0101;
    localparam logic [3:0] FuncNot = 4'b0110;
    localparam logic [3:0] FuncXor = 4'b0111;
    localparam logic [3:0] FuncMul = 4'b1000;

    typedef enum logic [3:0] {
        AluAdd     = 4'b0000,
        AluSub     = 4'b0001,
        AluSll     = 4'b0010,
        AluSlt     = 4'b0011,
        AluAnd     = 4'b0100,
        AluOr      = 4'b0101,
        AluNot     = 4'b0110,
        AluXor     = 4'b0111,
        AluMul     = 4'b1000,
        AluIllegal = 4'b1111
    } alu_code_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-left / shift-add multiply datapath; one step per cycle.
// Accumulator and multiplier operand exist only with ALU_SEQ_CTRL_MUL_EN.
module alu_iter_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
`ifdef ALU_SEQ_CTRL_MUL_EN
    input  logic              mul_i,
    input  logic [DATA_W-1:0] b_i,
`endif
    input  logic [DATA_W-1:0] a_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [DATA_W-1:0] next_o,
    output logic              last_o
);

    logic [DATA_W-1:0] opa_q, opa_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        opa_d = opa_q;
        cnt_d = cnt_q;
        if (load_i) begin
            opa_d = a_i;
            cnt_d = cnt_i;
        end else if (step_i) begin
            opa_d = opa_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opa_q <= '0;
            cnt_q <= '0;
        end else begin
            opa_q <= opa_d;
            cnt_q <= cnt_d;
        end
    end

    // The step that brings the counter to zero is the last one.
    assign last_o = (cnt_q == CNT_W'(1));

`ifdef ALU_SEQ_CTRL_MUL_EN
    logic              mul_q, mul_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_nxt;

    assign acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);

    always_comb begin
        mul_d = mul_q;
        opb_d = opb_q;
        acc_d = acc_q;
        if (load_i) begin
            mul_d = mul_i;
            opb_d = b_i;
            acc_d = '0;
        end else if (step_i) begin
            opb_d = opb_q >> 1;
            acc_d = acc_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_q <= 1'b0;
            opb_q <= '0;
            acc_q <= '0;
        end else begin
            mul_q <= mul_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
        end
    end

    assign next_o = mul_q ? acc_nxt : (opa_q << 1);
`else
    assign next_o = opa_q << 1;
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU control/sequencing unit: decode, single-cycle ALU, IDLE/EXEC/DONE FSM.
// Define ALU_SEQ_CTRL_MUL_EN to make R-type func 1000 an iterative multiply.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OPC_W  = 3,
    parameter int unsigned FUNC_W = 4,
    parameter int unsigned CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] result,
    output logic [CODE_W-1:0] alu_code,
    output logic              err
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W = SH_W + 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    alu_code_e         code_q, code_d;
    logic              err_q, err_d;

    alu_code_e         dec_code;
    logic              dec_iter;
    logic              dec_mul;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   sh_cnt;
    logic [CNT_W-1:0]  cnt_load;
    logic              iter_load, iter_step, iter_last;
    logic [DATA_W-1:0] iter_next;

    assign sh_cnt = src_b[SH_W-1:0];

    always_comb begin
        dec_code = AluIllegal;
        dec_iter = 1'b0;
        dec_mul  = 1'b0;
        case (opcode)
            OPC_W'(OpcRtype): begin
                case (func)
                    FUNC_W'(FuncAdd): dec_code = AluAdd;
                    FUNC_W'(FuncSub): dec_code = AluSub;
                    FUNC_W'(FuncSlt): dec_code = AluSlt;
                    FUNC_W'(FuncAnd): dec_code = AluAnd;
                    FUNC_W'(FuncOr):  dec_code = AluOr;
                    FUNC_W'(FuncNot): dec_code = AluNot;
                    FUNC_W'(FuncXor): dec_code = AluXor;
                    FUNC_W'(FuncSll): begin
                        dec_code = AluSll;
                        dec_iter = 1'b1;
                    end
`ifdef ALU_SEQ_CTRL_MUL_EN
                    FUNC_W'(FuncMul): begin
                        dec_code = AluMul;
                        dec_iter = 1'b1;
                        dec_mul  = 1'b1;
                    end
`endif
                    default: dec_code = AluIllegal;
                endcase
            end
            OPC_W'(OpcAddi): dec_code = AluAdd;
            OPC_W'(OpcSubi): dec_code = AluSub;
            default:         dec_code = AluIllegal;
        endcase
    end

    // Sll lands here only for a zero count, where the result is src_a.
    always_comb begin
        alu_res = '0;
        case (dec_code)
            AluAdd: alu_res = src_a + src_b;
            AluSub: alu_res = src_a - src_b;
            AluSlt: alu_res = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            AluAnd: alu_res = src_a & src_b;
            AluOr:  alu_res = src_a | src_b;
            AluNot: alu_res = ~src_a;
            AluXor: alu_res = src_a ^ src_b;
            AluSll: alu_res = src_a;
            default: alu_res = '0;
        endcase
    end

    assign cnt_load = dec_mul ? CNT_W'(DATA_W) : CNT_W'(sh_cnt);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        code_d    = code_q;
        err_d     = err_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    code_d = dec_code;
                    err_d  = (dec_code == AluIllegal);
                    if (dec_iter && (dec_mul || sh_cnt != '0)) begin
                        iter_load = 1'b1;
                        state_d   = StExec;
                    end else begin
                        result_d = alu_res;
                        state_d  = StDone;
                    end
                end
            end
            StExec: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    result_d = iter_next;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            code_q   <= AluAdd;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            code_q   <= code_d;
            err_q    <= err_d;
        end
    end

    alu_iter_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_iter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (iter_load),
        .step_i (iter_step),
`ifdef ALU_SEQ_CTRL_MUL_EN
        .mul_i  (dec_mul),
        .b_i    (src_b),
`endif
        .a_i    (src_a),
        .cnt_i  (cnt_load),
        .next_o (iter_next),
        .last_o (iter_last)
    );

    assign in_ready  = (state_q == StIdle);
    assign res_valid = (state_q == StDone);
    assign result    = result_q;
    assign alu_code  = CODE_W'(code_q);
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized and directed bench for alu_seq_ctrl against an arithmetic reference model.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic [3:0]  alu_code;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_ctrl #(
        .DATA_W (16),
        .OPC_W  (3),
        .FUNC_W (4),
        .CODE_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .func      (func),
        .src_a     (src_a),
        .src_b     (src_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .alu_code  (alu_code),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, code, err and accept-to-valid latency from the operation rules.
    function automatic void model(input logic [2:0] opc, input logic [3:0] fn,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] c,
                                  output logic e, output int lat);
        int sa;
        int sb;
        longint prod;
        r   = 16'h0;
        c   = 4'hF;
        e   = 1'b1;
        lat = 1;
        if (opc == 3'd1) begin
            r = a + b; c = 4'h0; e = 1'b0;
        end else if (opc == 3'd2) begin
            r = a - b; c = 4'h1; e = 1'b0;
        end else if (opc == 3'd0) begin
            c = fn; e = 1'b0;
            case (fn)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: begin
                    r   = a << (b % 16);
                    lat = int'(b % 16) + 1;
                end
                4'd3: begin
                    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
                    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
                    r  = (sa < sb) ? 16'd1 : 16'd0;
                end
                4'd4: r = a & b;
                4'd5: r = a | b;
                4'd6: r = ~a;
                4'd7: r = a ^ b;
`ifdef ALU_SEQ_CTRL_MUL_EN
                4'd8: begin
                    prod = longint'(a) * longint'(b);
                    r    = prod[15:0];
                    lat  = 17;
                end
`endif
                default: begin
                    r = 16'h0; c = 4'hF; e = 1'b1;
                end
            endcase
        end
    endfunction

    task automatic run_op(input logic [2:0] opc, input logic [3:0] fn, input logic [15:0] a,
                          input logic [15:0] b, input int hold);
        logic [15:0] er;
        logic [3:0]  ec;
        logic        ee;
        int          el;
        int          lat;
        model(opc, fn, a, b, er, ec, ee, el);
        @(negedge clk);
        check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
        opcode    = opc;
        func      = fn;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, el);
        check_eq("result", {16'd0, result}, {16'd0, er});
        check_eq("alu_code", {28'd0, alu_code}, {28'd0, ec});
        check_eq("err", {31'd0, err}, {31'd0, ee});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            opcode   = 3'($urandom);
            src_a    = 16'($urandom);
            @(posedge clk);
            #1;
            check_eq("hold_valid", {31'd0, res_valid}, 32'd1);
            check_eq("hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("hold_result", {16'd0, result}, {16'd0, er});
            check_eq("hold_err", {31'd0, err}, {31'd0, ee});
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_eq("post_xfer_valid", {31'd0, res_valid}, 32'd0);
        check_eq("post_xfer_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic [2:0] r_opc;
    logic [3:0] r_fn;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        opcode    = 3'd0;
        func      = 4'd0;
        src_a     = 16'd0;
        src_b     = 16'd0;
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_alu_code", {28'd0, alu_code}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 4'd0, 16'h7FFF, 16'h0001, 0);
        run_op(3'd2, 4'd0, 16'h0000, 16'h0001, 0);
        run_op(3'd0, 4'd3, 16'hFFFF, 16'h0001, 1);
        run_op(3'd0, 4'd3, 16'h0001, 16'hFFFF, 0);
        run_op(3'd0, 4'd2, 16'h0001, 16'h0005, 0);
        run_op(3'd0, 4'd2, 16'h1234, 16'h0000, 0);
        run_op(3'd0, 4'd2, 16'h0001, 16'h0013, 2);
        run_op(3'd0, 4'd8, 16'h0102, 16'h0003, 0);
        run_op(3'd0, 4'd8, 16'hFFFF, 16'hFFFF, 0);
        run_op(3'd7, 4'd0, 16'h1111, 16'h2222, 5);

        // Dropped in_valid pulses must not leave a pending operation behind.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("no_stray_result", {31'd0, res_valid}, 32'd0);
        end

        // Abort an iterative op in its eighth EXEC cycle.
        @(negedge clk);
        opcode   = 3'd0;
`ifdef ALU_SEQ_CTRL_MUL_EN
        func     = 4'd8;
`else
        func     = 4'd2;
`endif
        src_a    = 16'h0123;
        src_b    = 16'h000F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("exec_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, res_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 4'd0, 16'd2, 16'd3, 0);

        for (int k = 0; k < 60; k++) begin
            r_opc = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            r_fn  = 4'($urandom_range(0, 9));
            run_op(r_opc, r_fn, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
